// File: rtl/address_range_walker.sv
// Streams raw addresses (ADDR_BASE + index) mod 2**ADDR_WIDTH for {start, length} index-range commands.
// Optional descending sweeps are enabled by defining ADDRESS_WALKER_DESCEND_EN (adds input cmd_descend).
module address_range_walker #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned ADDR_BASE   = 0,
   parameter int unsigned ADDR_COUNT  = 1,
   parameter int unsigned INDEX_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [INDEX_WIDTH-1:0] cmd_start_index,
   input  logic [INDEX_WIDTH:0]   cmd_length,
`ifdef ADDRESS_WALKER_DESCEND_EN
   input  logic                   cmd_descend,
`endif
   output logic                   cmd_error,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_WIDTH-1:0]  out_address,
   output logic [INDEX_WIDTH-1:0] out_index,
   output logic                   out_last,
   output logic                   busy
);

   localparam int unsigned SUM_WIDTH = ADDR_WIDTH + INDEX_WIDTH;
   localparam logic [ADDR_WIDTH-1:0]  BASE_TRUNC = ADDR_WIDTH'(ADDR_BASE);
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(ADDR_COUNT - 1);
   localparam logic [INDEX_WIDTH:0]   COUNT_EXT  = (INDEX_WIDTH + 1)'(ADDR_COUNT);
   localparam logic [INDEX_WIDTH:0]   LEN_ONE    = (INDEX_WIDTH + 1)'(1);
   localparam logic [INDEX_WIDTH:0]   LEN_TWO    = (INDEX_WIDTH + 1)'(2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 state_q;
   logic                   cmdError_q;
   logic                   outValid_q;
   logic                   outLast_q;
   logic [ADDR_WIDTH-1:0]  outAddress_q;
   logic [INDEX_WIDTH-1:0] outIndex_q;
   logic [INDEX_WIDTH:0]   remaining_q;
   logic [INDEX_WIDTH-1:0] nextIndex_d;
   logic                   startIllegal;
`ifdef ADDRESS_WALKER_DESCEND_EN
   logic                   descend_q;
`endif

   // Sum is formed wide enough for both operands, then truncated to give the raw wrap-around.
   function automatic logic [ADDR_WIDTH-1:0] addrOf(input logic [INDEX_WIDTH-1:0] idx);
      logic [SUM_WIDTH-1:0] wide;
      wide = SUM_WIDTH'(BASE_TRUNC) + SUM_WIDTH'(idx);
      return wide[ADDR_WIDTH-1:0];
   endfunction

   assign startIllegal = ({1'b0, cmd_start_index} >= COUNT_EXT);

   always_comb begin
      nextIndex_d = (outIndex_q == LAST_IDX) ? '0 : outIndex_q + INDEX_WIDTH'(1);
`ifdef ADDRESS_WALKER_DESCEND_EN
      if (descend_q) begin
         nextIndex_d = (outIndex_q == '0) ? LAST_IDX : outIndex_q - INDEX_WIDTH'(1);
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cmdError_q   <= 1'b0;
         outValid_q   <= 1'b0;
         outLast_q    <= 1'b0;
         outAddress_q <= '0;
         outIndex_q   <= '0;
         remaining_q  <= '0;
`ifdef ADDRESS_WALKER_DESCEND_EN
         descend_q    <= 1'b0;
`endif
      end else begin
         cmdError_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (startIllegal) begin
                     cmdError_q <= 1'b1;
                  end else if (cmd_length != '0) begin
                     state_q      <= ST_RUN;
                     outValid_q   <= 1'b1;
                     outIndex_q   <= cmd_start_index;
                     outAddress_q <= addrOf(cmd_start_index);
                     outLast_q    <= (cmd_length == LEN_ONE);
                     remaining_q  <= cmd_length;
`ifdef ADDRESS_WALKER_DESCEND_EN
                     descend_q    <= cmd_descend;
`endif
                  end
               end
            end
            ST_RUN: begin
               // Outputs only move on a transfer, so a stalled beat stays stable.
               if (out_ready) begin
                  if (outLast_q) begin
                     state_q    <= ST_IDLE;
                     outValid_q <= 1'b0;
                     outLast_q  <= 1'b0;
                  end else begin
                     outIndex_q   <= nextIndex_d;
                     outAddress_q <= addrOf(nextIndex_d);
                     remaining_q  <= remaining_q - LEN_ONE;
                     outLast_q    <= (remaining_q == LEN_TWO);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_RUN);
   assign cmd_error   = cmdError_q;
   assign out_valid   = outValid_q;
   assign out_last    = outLast_q;
   assign out_address = outAddress_q;
   assign out_index   = outIndex_q;

endmodule

// File: tb/tb_address_range_walker.sv
// Self-checking bench for address_range_walker (ADDR_WIDTH=3, ADDR_BASE=6, ADDR_COUNT=5, INDEX_WIDTH=3).
// Expected beats come from a modular-arithmetic model of the index range, not from the RTL structure.
module tb_address_range_walker;

   localparam int AW    = 3;
   localparam int BASE  = 6;
   localparam int COUNT = 5;
   localparam int IW    = 3;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [IW-1:0] cmd_start_index = '0;
   logic [IW:0]   cmd_length = '0;
   logic          cmd_error;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_address;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          busy;
`ifdef ADDRESS_WALKER_DESCEND_EN
   logic          cmd_descend = 1'b0;
`endif

   int compared = 0;
   int mismatched = 0;

   address_range_walker #(
      .ADDR_WIDTH (AW),
      .ADDR_BASE  (BASE),
      .ADDR_COUNT (COUNT),
      .INDEX_WIDTH(IW)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_start_index(cmd_start_index),
      .cmd_length     (cmd_length),
`ifdef ADDRESS_WALKER_DESCEND_EN
      .cmd_descend    (cmd_descend),
`endif
      .cmd_error      (cmd_error),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_address    (out_address),
      .out_index      (out_index),
      .out_last       (out_last),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
   // maxBeats stops the sweep early (leaving the DUT mid-sweep) for the reset scenario.
   task automatic applyStimulus(input int start, input int len, input bit descend,
                                input int readyMode, input int maxBeats);
      int expIdx[$];
      int idx;
      int cycles;
      int taken;
      cmd_valid       = 1'b1;
      cmd_start_index = IW'(start);
      cmd_length      = (IW + 1)'(len);
`ifdef ADDRESS_WALKER_DESCEND_EN
      cmd_descend     = descend;
`endif
      checkOutput("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;

      if (start >= COUNT) begin
         checkOutput("cmd_error_pulse", 32'(cmd_error), 32'd1);
         checkOutput("illegal_no_valid", 32'(out_valid), 32'd0);
         checkOutput("illegal_idle", 32'(cmd_ready), 32'd1);
         @(posedge clock); #1;
         checkOutput("cmd_error_one_cycle", 32'(cmd_error), 32'd0);
         checkOutput("illegal_still_no_valid", 32'(out_valid), 32'd0);
      end else if (len == 0) begin
         checkOutput("empty_no_error", 32'(cmd_error), 32'd0);
         checkOutput("empty_no_valid", 32'(out_valid), 32'd0);
         checkOutput("empty_ready", 32'(cmd_ready), 32'd1);
      end else begin
         for (int k = 0; k < len; k++) begin
            if (descend) idx = (((start - k) % COUNT) + COUNT) % COUNT;
            else         idx = (start + k) % COUNT;
            expIdx.push_back(idx);
         end
         cycles = 0;
         taken  = 0;
         while (expIdx.size() > 0 && taken < maxBeats && cycles < 400) begin
            case (readyMode)
               0:       out_ready = 1'b1;
               1:       out_ready = ((cycles % 3) == 0);
               default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cmd_valid       = 1'($urandom_range(0, 1));
            cmd_start_index = IW'($urandom_range(0, 7));
            cmd_length      = (IW + 1)'($urandom_range(0, 15));
            checkOutput("beat_valid", 32'(out_valid), 32'd1);
            checkOutput("beat_busy", 32'(busy), 32'd1);
            checkOutput("beat_cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("beat_index", 32'(out_index), 32'(expIdx[0]));
            checkOutput("beat_address", 32'(out_address), 32'((BASE + expIdx[0]) % (1 << AW)));
            checkOutput("beat_last", 32'(out_last), 32'(expIdx.size() == 1));
            @(posedge clock); #1;
            if (out_ready) begin
               void'(expIdx.pop_front());
               taken++;
            end
            cycles++;
         end
         cmd_valid = 1'b0;
         out_ready = 1'b0;
         if (cycles >= 400) begin
            checkOutput("sweep_timeout", 32'(cycles), 32'd0);
         end else if (expIdx.size() == 0) begin
            checkOutput("done_valid_low", 32'(out_valid), 32'd0);
            checkOutput("done_cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("done_busy_low", 32'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      int rs;
      int rl;
      #3;
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_cmd_error", 32'(cmd_error), 32'd0);
      checkOutput("reset_out_address", 32'(out_address), 32'd0);
      checkOutput("reset_out_index", 32'(out_index), 32'd0);
      checkOutput("reset_out_last", 32'(out_last), 32'd0);
      #10 reset_n = 1'b1;
      @(posedge clock); #1;

      $display("[TB] wrap-around sweep");
      applyStimulus(0, 5, 1'b0, 0, 100);
      $display("[TB] index wrap and re-sweep");
      applyStimulus(3, 7, 1'b0, 0, 100);
      $display("[TB] back-pressure");
      applyStimulus(0, 5, 1'b0, 1, 100);
      $display("[TB] illegal and empty commands");
      applyStimulus(5, 2, 1'b0, 0, 100);
      applyStimulus(1, 0, 1'b0, 0, 100);
      applyStimulus(7, 15, 1'b0, 0, 100);

      $display("[TB] reset mid-sweep");
      applyStimulus(0, 5, 1'b0, 0, 2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort_valid_low", 32'(out_valid), 32'd0);
      checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("abort_busy_low", 32'(busy), 32'd0);
      checkOutput("abort_last_low", 32'(out_last), 32'd0);
      #10 reset_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("after_abort_no_valid", 32'(out_valid), 32'd0);
      applyStimulus(4, 1, 1'b0, 0, 100);

`ifdef ADDRESS_WALKER_DESCEND_EN
      $display("[TB] descending sweep");
      applyStimulus(1, 4, 1'b1, 0, 100);
      applyStimulus(3, 9, 1'b1, 2, 100);
`endif

      $display("[TB] randomized commands");
      for (int n = 0; n < 30; n++) begin
         rs = $urandom_range(0, 7);
         rl = $urandom_range(0, 15);
         applyStimulus(rs, rl, 1'b0, 2, 100);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
